// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift-register sequencer: FSM states, fill modes
// and shift directions.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] M_LOGIC = 2'b00;
    localparam logic [1:0] M_ARITH = 2'b01;
    localparam logic [1:0] M_ROT   = 2'b10;
    localparam logic [1:0] M_EXT   = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_fill_sel.sv
// Selects the bit leaving the register and the serial fill bit entering it,
// from the current register end bits and the latched request.
module shift_fill_sel
    import shift_ctrl_pkg::*;
(
    input  logic [1:0] mode_i,
    input  logic       dir_i,
    input  logic       q_msb_i,
    input  logic       q_lsb_i,
    input  logic       fill_in_i,
    output logic       out_o,
    output logic       fill_o
);

    always_comb begin
        out_o  = (dir_i == DIR_RIGHT) ? q_lsb_i : q_msb_i;
        fill_o = 1'b0;
        case (mode_i)
            M_LOGIC: fill_o = 1'b0;
            M_ARITH: fill_o = (dir_i == DIR_RIGHT) ? q_msb_i : 1'b0;
            M_ROT:   fill_o = out_o;
            M_EXT:   fill_o = fill_in_i;
            default: fill_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for the W-bit parallel/serial shift register: loads a word, issues
// up to W single-bit shifts, collects the shifted-out bits and pulses done.
module shift_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int W  = 4,
    parameter int AW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          ready,
    input  logic [W-1:0]  data_in,
    input  logic [AW-1:0] amount,
    input  logic          dir,
    input  logic [1:0]    mode,
    input  logic          fill_in,
    input  logic [W-1:0]  q_in,
    output logic          ps,
    output logic          rl,
    output logic          sir,
    output logic          sil,
    output logic [W-1:0]  par_data,
    output logic [W-1:0]  spill,
    output logic          done
);

    localparam logic [AW-1:0] W_AMT = AW'(W);

    state_t        state_q, state_d;
    logic [AW-1:0] count_q, count_d;
    logic [AW-1:0] n_q, n_d;
    logic [W-1:0]  spill_q, spill_d;
    logic [W-1:0]  data_q, data_d;
    logic          dir_q, dir_d;
    logic [1:0]    mode_q, mode_d;
    logic          fill_q, fill_d;

    logic          out_bit;
    logic          fill_bit;

    shift_fill_sel u_fill_sel (
        .mode_i    (mode_q),
        .dir_i     (dir_q),
        .q_msb_i   (q_in[W-1]),
        .q_lsb_i   (q_in[0]),
        .fill_in_i (fill_q),
        .out_o     (out_bit),
        .fill_o    (fill_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            n_q     <= '0;
            spill_q <= '0;
            data_q  <= '0;
            dir_q   <= 1'b0;
            mode_q  <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            n_q     <= n_d;
            spill_q <= spill_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        n_d      = n_q;
        spill_d  = spill_q;
        data_d   = data_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        fill_d   = fill_q;

        ready    = 1'b0;
        done     = 1'b0;
        ps       = 1'b1;
        rl       = 1'b0;
        sir      = 1'b0;
        sil      = 1'b0;
        par_data = data_q;

        case (state_q)
            S_IDLE: begin
                ready    = 1'b1;
                // The register has no hold mode: reload its own contents.
                par_data = q_in;
                if (start) begin
                    data_d  = data_in;
                    dir_d   = dir;
                    mode_d  = mode;
                    fill_d  = fill_in;
                    n_d     = (amount > W_AMT) ? W_AMT : amount;
                    spill_d = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = n_q;
                state_d = (n_q != '0) ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
                ps      = 1'b0;
                rl      = dir_q;
                sir     = (dir_q == DIR_LEFT)  ? fill_bit : 1'b0;
                sil     = (dir_q == DIR_RIGHT) ? fill_bit : 1'b0;
                count_d = count_q - AW'(1);
                spill_d = (dir_q == DIR_LEFT) ? {spill_q[W-2:0], out_bit}
                                              : {out_bit, spill_q[W-1:1]};
                if (count_q == AW'(1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                par_data = q_in;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign spill = spill_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl driving a behavioural W=4 shift register; results
// are checked against a per-request arithmetic reference model.
module tb_shift_seq_ctrl;

    localparam int W  = 4;
    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic          ready;
    logic [W-1:0]  data_in;
    logic [AW-1:0] amount;
    logic          dir;
    logic [1:0]    mode;
    logic          fill_in;
    logic [W-1:0]  q_reg;
    logic          ps, rl, sir, sil;
    logic [W-1:0]  par_data;
    logic [W-1:0]  spill;
    logic          done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [W-1:0] trace_q[$];

    shift_seq_ctrl #(.W(W), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ready    (ready),
        .data_in  (data_in),
        .amount   (amount),
        .dir      (dir),
        .mode     (mode),
        .fill_in  (fill_in),
        .q_in     (q_reg),
        .ps       (ps),
        .rl       (rl),
        .sir      (sir),
        .sil      (sil),
        .par_data (par_data),
        .spill    (spill),
        .done     (done)
    );

    // Shift register: PS=1 parallel load, else shift in SIR (left) or SIL (right).
    always_ff @(posedge clk) begin
        if (rst)       q_reg <= '0;
        else if (ps)   q_reg <= par_data;
        else if (!rl)  q_reg <= {q_reg[W-2:0], sir};
        else           q_reg <= {sil, q_reg[W-1:1]};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input logic [3:0] d, input logic [2:0] amt,
                                  input logic dr, input logic [1:0] md, input logic fl,
                                  output logic [3:0] res, output logic [3:0] sp,
                                  output int n);
        logic ob, fb;
        n   = (amt > 3'd4) ? 4 : int'(amt);
        res = d;
        sp  = '0;
        for (int i = 0; i < n; i++) begin
            ob = dr ? res[0] : res[3];
            case (md)
                2'b00:   fb = 1'b0;
                2'b01:   fb = dr ? res[3] : 1'b0;
                2'b10:   fb = ob;
                default: fb = fl;
            endcase
            if (!dr) begin
                res = {res[2:0], fb};
                sp  = {sp[2:0], ob};
            end else begin
                res = {fb, res[3:1]};
                sp  = {ob, sp[3:1]};
            end
        end
    endfunction

    // Drives one request and collects the register trace until done (bounded).
    task automatic run_op(input logic [3:0] d, input logic [2:0] amt, input logic dr,
                          input logic [1:0] md, input logic fl,
                          output logic rdy0, output logic [3:0] res, output logic [3:0] sp,
                          output int cyc, output logic done_next);
        @(negedge clk);
        rdy0    = ready;
        start   = 1'b1;
        data_in = d;
        amount  = amt;
        dir     = dr;
        mode    = md;
        fill_in = fl;
        @(negedge clk);
        start = 1'b0;
        trace_q.delete();
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            trace_q.push_back(q_reg);
        end
        res = q_reg;
        sp  = spill;
        @(negedge clk);
        done_next = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; data_in = 4'b1111; amount = 3'd2;
        dir = 1'b0; mode = 2'b00; fill_in = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({ready, done, ps, rl, sir, sil} !== 6'b101000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 101000", {ready, done, ps, rl, sir, sil});
        end
        tests_run++;
        if (spill !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_spill: got %b expected 0000", spill);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (ready !== 1'b1 || q_reg !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_start_ignored: ready=%b q=%b expected ready=1 q=0000", ready, q_reg);
        end
    endtask

    task automatic test_logical_left();
        logic r0, dn; logic [3:0] res, sp; int cyc;
        logic [3:0] exp_tr[3] = '{4'b1011, 4'b0110, 4'b1100};
        run_op(4'b1011, 3'd2, 1'b0, 2'b00, 1'b0, r0, res, sp, cyc, dn);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (trace_q[i] !== exp_tr[i]) begin
                tests_failed++;
                $display("FAIL lsl_trace[%0d]: got %b expected %b", i, trace_q[i], exp_tr[i]);
            end
        end
        tests_run++;
        if (sp !== 4'b0010 || cyc != 3 || dn !== 1'b0) begin
            tests_failed++;
            $display("FAIL lsl_done: spill=%b cyc=%0d done_next=%b expected 0010 3 0", sp, cyc, dn);
        end
    endtask

    task automatic test_arith_right();
        logic r0, dn; logic [3:0] res, sp; int cyc;
        logic [3:0] exp_tr[4] = '{4'b1001, 4'b1100, 4'b1110, 4'b1111};
        run_op(4'b1001, 3'd3, 1'b1, 2'b01, 1'b0, r0, res, sp, cyc, dn);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (trace_q[i] !== exp_tr[i]) begin
                tests_failed++;
                $display("FAIL asr_trace[%0d]: got %b expected %b", i, trace_q[i], exp_tr[i]);
            end
        end
        tests_run++;
        if (sp !== 4'b0010 || cyc != 4) begin
            tests_failed++;
            $display("FAIL asr_done: spill=%b cyc=%0d expected 0010 4", sp, cyc);
        end
    endtask

    task automatic test_rotate();
        logic r0, dn; logic [3:0] res, sp; int cyc;
        run_op(4'b1000, 3'd4, 1'b0, 2'b10, 1'b0, r0, res, sp, cyc, dn);
        tests_run++;
        if (res !== 4'b1000 || sp !== 4'b1000 || cyc != 5) begin
            tests_failed++;
            $display("FAIL rol4: res=%b spill=%b cyc=%0d expected 1000 1000 5", res, sp, cyc);
        end
        run_op(4'b0001, 3'd1, 1'b1, 2'b10, 1'b0, r0, res, sp, cyc, dn);
        tests_run++;
        if (res !== 4'b1000 || sp !== 4'b1000 || cyc != 2) begin
            tests_failed++;
            $display("FAIL ror1: res=%b spill=%b cyc=%0d expected 1000 1000 2", res, sp, cyc);
        end
    endtask

    task automatic test_clamp_and_zero();
        logic r0, dn; logic [3:0] res, sp; int cyc;
        run_op(4'b1111, 3'd7, 1'b0, 2'b00, 1'b0, r0, res, sp, cyc, dn);
        tests_run++;
        if (res !== 4'b0000 || sp !== 4'b1111 || cyc != 5) begin
            tests_failed++;
            $display("FAIL clamp: res=%b spill=%b cyc=%0d expected 0000 1111 5", res, sp, cyc);
        end
        run_op(4'b0101, 3'd0, 1'b0, 2'b00, 1'b0, r0, res, sp, cyc, dn);
        tests_run++;
        if (res !== 4'b0101 || sp !== 4'b0000 || cyc != 1) begin
            tests_failed++;
            $display("FAIL zero_amt: res=%b spill=%b cyc=%0d expected 0101 0000 1", res, sp, cyc);
        end
    endtask

    task automatic test_idle_hold();
        logic r0, dn; logic [3:0] res, sp; int cyc;
        run_op(4'b0110, 3'd0, 1'b0, 2'b00, 1'b0, r0, res, sp, cyc, dn);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if (q_reg !== 4'b0110 || ps !== 1'b1) begin
                tests_failed++;
                $display("FAIL idle_hold[%0d]: q=%b ps=%b expected 0110 1", i, q_reg, ps);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        @(negedge clk);
        start = 1'b1; data_in = 4'b1011; amount = 3'd3; dir = 1'b0; mode = 2'b00; fill_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; data_in = 4'b0000; amount = 3'd0;
        cyc = 0;
        while (!done && cyc < 20) begin
            tests_run++;
            if (ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL busy_ready[%0d]: got %b expected 0", cyc, ready);
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        tests_run++;
        if (q_reg !== 4'b1000 || spill !== 4'b0101 || cyc != 3) begin
            tests_failed++;
            $display("FAIL busy_result: q=%b spill=%b cyc=%0d expected 1000 0101 3", q_reg, spill, cyc);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (ready !== 1'b1 || q_reg !== 4'b1000) begin
            tests_failed++;
            $display("FAIL busy_no_queue: ready=%b q=%b expected 1 1000", ready, q_reg);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic r0, dn; logic [3:0] res, sp, eres, esp; int cyc, n;
        @(negedge clk);
        start = 1'b1; data_in = 4'b1100; amount = 3'd4; dir = 1'b0; mode = 2'b00; fill_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (ready !== 1'b1 || spill !== 4'b0000 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid: ready=%b spill=%b done=%b expected 1 0000 0", ready, spill, done);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (done !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_no_done[%0d]: got %b expected 0", i, done);
            end
        end
        run_op(4'b0110, 3'd2, 1'b1, 2'b11, 1'b1, r0, res, sp, cyc, dn);
        model(4'b0110, 3'd2, 1'b1, 2'b11, 1'b1, eres, esp, n);
        tests_run++;
        if (res !== eres || sp !== esp || cyc != n + 1) begin
            tests_failed++;
            $display("FAIL rst_recover: res=%b spill=%b cyc=%0d expected %b %b %0d",
                     res, sp, cyc, eres, esp, n + 1);
        end
    endtask

    task automatic test_random();
        logic r0, dn, dr, fl; logic [1:0] md; logic [2:0] amt;
        logic [3:0] d, res, sp, eres, esp; int cyc, n;
        for (int t = 0; t < 40; t++) begin
            d   = 4'($urandom);
            amt = 3'($urandom);
            dr  = 1'($urandom);
            md  = 2'($urandom);
            fl  = 1'($urandom);
            run_op(d, amt, dr, md, fl, r0, res, sp, cyc, dn);
            model(d, amt, dr, md, fl, eres, esp, n);
            tests_run++;
            if (r0 !== 1'b1 || res !== eres || sp !== esp || cyc != n + 1 || dn !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand[%0d] d=%b amt=%0d dir=%b mode=%b fill=%b: rdy=%b res=%b spill=%b cyc=%0d dn=%b expected 1 %b %b %0d 0",
                         t, d, amt, dr, md, fl, r0, res, sp, cyc, dn, eres, esp, n + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_logical_left();
        test_arith_right();
        test_rotate();
        test_clamp_and_zero();
        test_idle_hold();
        test_start_while_busy();
        test_reset_mid_shift();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencer directly upstream of the team's W-bit parallel/serial shift register. It drives the register's PS, RL, SIR, SIL and DATA inputs and monitors its output through q_in.
- Accepts one shift request per handshake: data, amount, direction, mode.
- Loads the register, issues the requested number of single-bit shifts, and captures the shifted-out bits.
- Holds the register stable while idle and signals completion.

Parameters:
W, 4, data width; must equal the shift register width (W >= 2).
AW, $clog2(W)+1, width of the amount field.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  request valid
ready  out  1  high when in IDLE; a request is accepted on a clock edge where start && ready
data_in  in  W  word to load
amount  in  AW  number of shifts; values above W are clamped to W
dir  in  1  0 = left (toward MSB), 1 = right
mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 external fill
fill_in  in  1  fill bit used when mode = 11
q_in  in  W  current register contents (outREG)
ps  out  1  register PS (1 = parallel load)
rl  out  1  register RL (0 = left, 1 = right)
sir  out  1  serial bit entering the LSB on a left shift
sil  out  1  serial bit entering the MSB on a right shift
par_data  out  W  register DATA
spill  out  W  shifted-out bits of the last operation
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous): state=IDLE, latched request cleared, count=0, spill=0, done=0. A start sampled in a reset cycle is ignored.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - ready=1; ps=1; par_data=q_in, so the register reloads its own value. The register has no hold mode, so this is mandatory.
  - On start: latch data_in, dir, mode, fill_in, and n = min(amount, W).
  - Go to LOAD. Clear spill.
- LOAD (1 cycle):
  - ps=1, par_data=latched data.
  - Next state is SHIFT if n>0, else DONE. Load count=n.
- SHIFT (n cycles):
  - ps=0, rl=latched dir.
  - Each edge decrements count; leave for DONE on the edge where count goes 1->0.
  - Out bit: q_in[W-1] when dir=0, q_in[0] when dir=1.
  - Spill update: dir=0 gives spill <= {spill[W-2:0], out}; dir=1 gives spill <= {out, spill[W-1:1]}.
- Fill bit (combinational from q_in and the latched request):
  - Logical: 0.
  - Arithmetic: left 0; right q_in[W-1].
  - Rotate: the out bit.
  - External: fill_in.
  - The fill goes to sir when dir=0 and to sil when dir=1. The unused serial input is driven 0.
  - sir and sil are 0 outside SHIFT.
- DONE (1 cycle):
  - done=1, ready=0; ps=1 with par_data=q_in (hold).
  - q_in holds the final result. Next state is IDLE.
- Latency: with acceptance at edge E0, the register loads at E0+1, shifts at E0+2 .. E0+n+1, and done is high in the cycle after edge E0+n+1.
- start while not ready: ignored, with no queuing.
- rl is 0 in every state except SHIFT. par_data is don't-care in SHIFT; drive latched data.
- Reset mid-operation: abort with no done pulse. The register is reset by the same rst.
- Outputs ps, rl, sir, sil and par_data are combinational from state and q_in. spill, done-state and count are registered.

Decomposition:
- Shared package/include shift_ctrl_pkg holds:
  - State encodings S_IDLE, S_LOAD, S_SHIFT, S_DONE.
  - Mode constants M_LOGIC=2'b00, M_ARITH=2'b01, M_ROT=2'b10, M_EXT=2'b11.
  - DIR_LEFT=0, DIR_RIGHT=1.
- One sub-module, shift_fill_sel: combinational selection of the fill and out bits from mode, dir, q_in and fill_in.
- The bench instantiates shift_seq_ctrl together with the real shift register.

Test Plan:
- All scenarios use W=4.
- data=1011, dir=0, mode=00, amount=2 -> register 1011, 0110, 1100; spill=0010; done exactly 3 cycles after acceptance.
- data=1001, dir=1, mode=01, amount=3 -> 1100, 1110, 1111; spill=0010.
- data=1000, dir=0, mode=10, amount=4 -> result 1000; spill=1000. Then dir=1 rotate of 0001 by 1 -> 1000.
- data=1111, dir=0, mode=00, amount=7 -> clamped to 4 shifts; result 0000; spill=1111. Then amount=0 with data 0101 -> load only; result 0101; done 1 cycle after acceptance.
- Idle hold: no start for 10 cycles after a load of 0110 -> q_in stays 0110, ps=1 throughout. start pulsed during SHIFT -> ignored, and ready stays 0 until IDLE.
- rst asserted mid-SHIFT -> next cycle state IDLE, ready=1, spill=0, no done pulse; a new request then completes normally.
